// File: rtl/vid_timing_gen.sv
// Video timing generator for four fixed display modes, with a configurable output delay line.
// Optional FIFO-underflow monitor is enabled by defining VTG_UNDERFLOW_EN.
module vid_timing_gen #(
    parameter int CNT_W   = 12,
    parameter int OUT_DLY = 1
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             enable,
    input  logic             rd_fifo_empty,
    output logic             hs,
    output logic             vs,
    output logic             de,
    output logic             polarity,
    output logic [CNT_W-1:0] hcnt,
    output logic [CNT_W-1:0] vcnt,
    output logic             frame_start,
    output logic             line_start,
    output logic             underflow,
    output logic [15:0]      underflow_cnt
);

    // Sync windows are stored as [beg, end) so every compare is a plain CNT_W-bit compare.
    typedef struct packed {
        logic [CNT_W-1:0] htot;
        logic [CNT_W-1:0] hact;
        logic [CNT_W-1:0] hs_beg;
        logic [CNT_W-1:0] hs_end;
        logic [CNT_W-1:0] vtot;
        logic [CNT_W-1:0] vact;
        logic [CNT_W-1:0] vs_beg;
        logic [CNT_W-1:0] vs_end;
        logic             pol;
    } timing_t;

    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
        logic pol;
        logic fs;
        logic ls;
    } stage_t;

    function automatic timing_t mode_timing(input logic [1:0] m);
        timing_t t;
        case (m)
            2'd1:    t = '{htot: CNT_W'(1344), hact: CNT_W'(1024), hs_beg: CNT_W'(1048), hs_end: CNT_W'(1184),
                           vtot: CNT_W'(806),  vact: CNT_W'(768),  vs_beg: CNT_W'(771),  vs_end: CNT_W'(777),
                           pol: 1'b0};
            2'd2:    t = '{htot: CNT_W'(2200), hact: CNT_W'(1920), hs_beg: CNT_W'(2008), hs_end: CNT_W'(2052),
                           vtot: CNT_W'(1125), vact: CNT_W'(1080), vs_beg: CNT_W'(1084), vs_end: CNT_W'(1089),
                           pol: 1'b1};
            2'd3:    t = '{htot: CNT_W'(1650), hact: CNT_W'(1280), hs_beg: CNT_W'(1390), hs_end: CNT_W'(1430),
                           vtot: CNT_W'(750),  vact: CNT_W'(720),  vs_beg: CNT_W'(725),  vs_end: CNT_W'(730),
                           pol: 1'b1};
            default: t = '{htot: CNT_W'(1904), hact: CNT_W'(1440), hs_beg: CNT_W'(1520), hs_end: CNT_W'(1672),
                           vtot: CNT_W'(934),  vact: CNT_W'(900),  vs_beg: CNT_W'(903),  vs_end: CNT_W'(909),
                           pol: 1'b0};
        endcase
        return t;
    endfunction

    function automatic logic mode_pol(input logic [1:0] m);
        timing_t t;
        t = mode_timing(m);
        return t.pol;
    endfunction

    logic [CNT_W-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic [1:0]       mode_q, mode_d, cur_mode;
    logic             en_q, rise, h_last, v_last, frame_last;
    timing_t          tm;
    stage_t           raw, rst_stage, out_s;
    stage_t           dly_q [OUT_DLY];

    always_comb begin
        rise       = enable & ~en_q;
        cur_mode   = rise ? mode : mode_q;
        tm         = mode_timing(cur_mode);
        h_last     = (hcnt_q == tm.htot - CNT_W'(1));
        v_last     = (vcnt_q == tm.vtot - CNT_W'(1));
        frame_last = enable & h_last & v_last;

        hcnt_d = '0;
        vcnt_d = '0;
        mode_d = mode_q;
        if (enable) begin
            if (h_last) begin
                vcnt_d = v_last ? '0 : vcnt_q + CNT_W'(1);
            end else begin
                hcnt_d = hcnt_q + CNT_W'(1);
                vcnt_d = vcnt_q;
            end
            if (rise || frame_last) mode_d = mode;
        end

        raw    = '0;
        raw.de = enable & (hcnt_q < tm.hact) & (vcnt_q < tm.vact);
        raw.hs = enable & (hcnt_q >= tm.hs_beg) & (hcnt_q < tm.hs_end);
        raw.vs = enable & (vcnt_q >= tm.vs_beg) & (vcnt_q < tm.vs_end);
        raw.fs = enable & (hcnt_q == '0) & (vcnt_q == '0);
        raw.ls = enable & (hcnt_q == '0) & (vcnt_q < tm.vact);
        // On the last pixel of a frame the incoming mode's polarity is already shown.
        raw.pol = frame_last ? mode_pol(mode) : tm.pol;

        rst_stage     = '0;
        rst_stage.pol = mode_pol(mode);
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
            mode_q <= mode;
            en_q   <= 1'b0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
            mode_q <= mode_d;
            en_q   <= enable;
        end
    end

    // Output delay line: sync flags travel as active-sense bits next to their polarity.
    always_ff @(posedge pclk) begin
        if (rst) begin
            for (int i = 0; i < OUT_DLY; i++) dly_q[i] <= rst_stage;
        end else begin
            dly_q[0] <= raw;
            for (int i = 1; i < OUT_DLY; i++) dly_q[i] <= dly_q[i-1];
        end
    end

    assign out_s       = dly_q[OUT_DLY-1];
    assign de          = out_s.de;
    assign polarity    = out_s.pol;
    assign hs          = ~(out_s.hs ^ out_s.pol);
    assign vs          = ~(out_s.vs ^ out_s.pol);
    assign frame_start = out_s.fs;
    assign line_start  = out_s.ls;
    assign hcnt        = hcnt_q;
    assign vcnt        = vcnt_q;

`ifdef VTG_UNDERFLOW_EN
    logic        uf_q, uf_d, uf_hit;
    logic [15:0] ufc_q, ufc_d;

    always_comb begin
        uf_hit = out_s.de & rd_fifo_empty;
        if (out_s.fs) begin
            uf_d  = uf_hit;
            ufc_d = {15'd0, uf_hit};
        end else begin
            uf_d  = uf_q | uf_hit;
            ufc_d = (uf_hit && ufc_q != 16'hFFFF) ? ufc_q + 16'd1 : ufc_q;
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            uf_q  <= 1'b0;
            ufc_q <= '0;
        end else begin
            uf_q  <= uf_d;
            ufc_q <= ufc_d;
        end
    end

    assign underflow     = uf_q;
    assign underflow_cnt = ufc_q;
`else
    logic unused_fifo_empty;
    assign unused_fifo_empty = rd_fifo_empty;
    assign underflow         = 1'b0;
    assign underflow_cnt     = '0;
`endif

endmodule

// File: tb/tb_vid_timing_gen.sv
// Bench for vid_timing_gen: table-driven line measurements, directed corner sequences,
// and randomized stimulus checked every cycle against a reference model.
module tb_vid_timing_gen;
    localparam int CW = 12;

    logic pclk = 1'b0;
    logic rst = 1'b1;
    logic [1:0] mode = 2'd2;
    logic enable = 1'b0;
    logic empty = 1'b0;

    logic hs1, vs1, de1, pol1, fs1, ls1, uf1;
    logic hs3, vs3, de3, pol3, fs3, ls3, uf3;
    logic [CW-1:0] hc1, vc1, hc3, vc3;
    logic [15:0] ufc1, ufc3;

    vid_timing_gen #(.CNT_W(CW), .OUT_DLY(1)) u1 (
        .pclk(pclk), .rst(rst), .mode(mode), .enable(enable), .rd_fifo_empty(empty),
        .hs(hs1), .vs(vs1), .de(de1), .polarity(pol1), .hcnt(hc1), .vcnt(vc1),
        .frame_start(fs1), .line_start(ls1), .underflow(uf1), .underflow_cnt(ufc1));

    vid_timing_gen #(.CNT_W(CW), .OUT_DLY(3)) u3 (
        .pclk(pclk), .rst(rst), .mode(mode), .enable(enable), .rd_fifo_empty(1'b0),
        .hs(hs3), .vs(vs3), .de(de3), .polarity(pol3), .hcnt(hc3), .vcnt(vc3),
        .frame_start(fs3), .line_start(ls3), .underflow(uf3), .underflow_cnt(ufc3));

    always #5 pclk = ~pclk;

    int checks = 0;
    int errors = 0;

    int HACT [4] = '{1440, 1024, 1920, 1280};
    int HFP  [4] = '{80, 24, 88, 110};
    int HSY  [4] = '{152, 136, 44, 40};
    int HBP  [4] = '{232, 160, 148, 220};
    int VACT [4] = '{900, 768, 1080, 720};
    int VFP  [4] = '{3, 3, 4, 5};
    int VSY  [4] = '{6, 6, 5, 5};
    int VBP  [4] = '{25, 29, 36, 20};
    bit POL  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

    function automatic int htot(input int m);
        return HACT[m] + HFP[m] + HSY[m] + HBP[m];
    endfunction

    function automatic int vtot(input int m);
        return VACT[m] + VFP[m] + VSY[m] + VBP[m];
    endfunction

    typedef struct packed {
        logic de, hs, vs, pol, fs, ls;
    } st_t;

    // Reference model: pixel position, mode in force, and the last four "as described" records.
    int  mh, mv, mmode, mufc;
    bit  men, muf;
    st_t pipe [4];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic mstep();
        st_t r;
        bit rise, hit, last;
        int cur;
        if (rst) begin
            mh = 0; mv = 0; mmode = int'(mode); men = 0; muf = 0; mufc = 0;
            r = '0;
            r.pol = POL[mode];
            for (int i = 0; i < 4; i++) pipe[i] = r;
            return;
        end
        hit = pipe[0].de && empty;
`ifdef VTG_UNDERFLOW_EN
        if (pipe[0].fs) begin
            mufc = hit ? 1 : 0;
            muf  = hit;
        end else if (hit) begin
            muf = 1;
            if (mufc < 65535) mufc++;
        end
`else
        if (hit) mufc = 0;
`endif
        rise = enable && !men;
        cur  = rise ? int'(mode) : mmode;
        last = enable && (mh == htot(cur) - 1) && (mv == vtot(cur) - 1);
        r = '0;
        if (enable) begin
            r.de = (mh < HACT[cur]) && (mv < VACT[cur]);
            r.hs = (mh >= HACT[cur] + HFP[cur]) && (mh < HACT[cur] + HFP[cur] + HSY[cur]);
            r.vs = (mv >= VACT[cur] + VFP[cur]) && (mv < VACT[cur] + VFP[cur] + VSY[cur]);
            r.fs = (mh == 0) && (mv == 0);
            r.ls = (mh == 0) && (mv < VACT[cur]);
        end
        r.pol = last ? POL[mode] : POL[cur];
        for (int i = 3; i > 0; i--) pipe[i] = pipe[i-1];
        pipe[0] = r;
        if (enable) begin
            if (rise || last) mmode = int'(mode);
            mh++;
            if (mh == htot(cur)) begin
                mh = 0;
                mv++;
                if (mv == vtot(cur)) mv = 0;
            end
        end else begin
            mh = 0;
            mv = 0;
        end
        men = enable;
    endtask

    task automatic chk_outputs();
        st_t e1, e3;
        logic [46:0] exp1, exp3, act1, act3;
        e1 = pipe[0];
        e3 = pipe[2];
        exp1 = {(e1.hs ? e1.pol : ~e1.pol), (e1.vs ? e1.pol : ~e1.pol), e1.de, e1.pol, e1.fs, e1.ls,
                muf, 16'(mufc), 12'(mh), 12'(mv)};
        exp3 = {(e3.hs ? e3.pol : ~e3.pol), (e3.vs ? e3.pol : ~e3.pol), e3.de, e3.pol, e3.fs, e3.ls,
                1'b0, 16'd0, 12'(mh), 12'(mv)};
        act1 = {hs1, vs1, de1, pol1, fs1, ls1, uf1, ufc1, hc1, vc1};
        act3 = {hs3, vs3, de3, pol3, fs3, ls3, uf3, ufc3, hc3, vc3};
        chk("model_dly1", 64'(act1), 64'(exp1));
        chk("model_dly3", 64'(act3), 64'(exp3));
    endtask

    task automatic tick();
        @(posedge pclk);
        mstep();
        #1;
        chk_outputs();
    endtask

    task automatic do_reset(input logic [1:0] m);
        rst = 1'b1; mode = m; enable = 1'b0; empty = 1'b0;
        tick();
        tick();
    endtask

    typedef struct {
        logic [1:0] m;
        int period, de_cnt, hs_len, hs_off;
        logic pol;
    } row_t;

    row_t rows [4];

    task automatic measure_lines(input string tag, input int budget, input logic exp_pol,
                                 output int period, output int de_cnt, output int hs_len, output int hs_off);
        int lsq[$];
        bit deq[$], hsq[$];
        period = -1; de_cnt = 0; hs_len = 0; hs_off = -1;
        for (int n = 0; n < budget; n++) begin
            tick();
            if (ls1) lsq.push_back(n);
            deq.push_back(de1);
            hsq.push_back(hs1 == exp_pol);
        end
        if (lsq.size() < 2) begin
            chk({tag, "_two_line_starts"}, 64'(lsq.size()), 64'd2);
            return;
        end
        period = lsq[1] - lsq[0];
        for (int k = lsq[0]; k < lsq[1]; k++) begin
            if (deq[k]) de_cnt++;
            if (hsq[k]) begin
                hs_len++;
                if (hs_off < 0) hs_off = k - lsq[0];
            end
        end
    endtask

    int hist_q [$];

    initial begin
        int p, d, hl, ho, fs_first;
        logic [4:0] cur3;

        rows[0] = '{m: 2'd2, period: 2200, de_cnt: 1920, hs_len: 44,  hs_off: 2008, pol: 1'b1};
        rows[1] = '{m: 2'd0, period: 1904, de_cnt: 1440, hs_len: 152, hs_off: 1520, pol: 1'b0};
        rows[2] = '{m: 2'd1, period: 1344, de_cnt: 1024, hs_len: 136, hs_off: 1048, pol: 1'b0};
        rows[3] = '{m: 2'd3, period: 1650, de_cnt: 1280, hs_len: 40,  hs_off: 1390, pol: 1'b1};

        // Reset state, both polarities.
        do_reset(2'd2);
        chk("rst_hcnt", 64'(hc1), 64'd0);
        chk("rst_vcnt", 64'(vc1), 64'd0);
        chk("rst_de", 64'(de1), 64'd0);
        chk("rst_hs_inactive_pos", 64'(hs1), 64'd0);
        chk("rst_vs_inactive_pos", 64'(vs1), 64'd0);
        chk("rst_fs", 64'(fs1), 64'd0);
        chk("rst_underflow_cnt", 64'(ufc1), 64'd0);
        do_reset(2'd0);
        chk("rst_hs_inactive_neg", 64'(hs1), 64'd1);
        chk("rst_pol_neg", 64'(pol1), 64'd0);

        // Table-driven line measurements per mode.
        for (int r = 0; r < 4; r++) begin
            do_reset(rows[r].m);
            rst = 1'b0; enable = 1'b1;
            tick();
            fs_first = fs1;
            chk("first_frame_start", 64'(fs_first), 64'd1);
            chk("polarity", 64'(pol1), 64'(rows[r].pol));
            measure_lines("line", 2 * rows[r].period + 50, rows[r].pol, p, d, hl, ho);
            chk("line_period", 64'(p), 64'(rows[r].period));
            chk("de_per_line", 64'(d), 64'(rows[r].de_cnt));
            chk("hs_len", 64'(hl), 64'(rows[r].hs_len));
            chk("hs_offset", 64'(ho), 64'(rows[r].hs_off));
        end

        // OUT_DLY=3 trails OUT_DLY=1 by exactly two cycles; counters identical.
        do_reset(2'd1);
        rst = 1'b0; enable = 1'b1;
        for (int n = 0; n < 1400; n++) begin
            tick();
            hist_q.push_back({de1, hs1, vs1, fs1, ls1});
            cur3 = {de3, hs3, vs3, fs3, ls3};
            if (n >= 2) chk("dly3_vs_dly1", 64'({cur3, hc3}), 64'({5'(hist_q[n-2]), hc1}));
        end

        // Reset mid-line, then restart.
        do_reset(2'd2);
        rst = 1'b0; enable = 1'b1;
        for (int n = 0; n < 1000; n++) tick();
        rst = 1'b1;
        tick();
        chk("midrst_hcnt", 64'(hc1), 64'd0);
        chk("midrst_de", 64'(de1), 64'd0);
        chk("midrst_hs", 64'(hs1), 64'd0);
        chk("midrst_ls", 64'(ls1), 64'd0);
        rst = 1'b0;
        tick();
        chk("fs_1_after_rst", 64'(fs1), 64'd1);
        tick();
        chk("fs_pulse_single", 64'(fs1), 64'd0);
        tick();
        chk("fs_dly3_after_rst", 64'(fs3), 64'd1);

        // Mid-frame mode change must not disturb the running frame.
        do_reset(2'd1);
        rst = 1'b0; enable = 1'b1;
        for (int n = 0; n < 100; n++) tick();
        mode = 2'd3;
        measure_lines("midchg", 2 * 1344 + 20, 1'b0, p, d, hl, ho);
        chk("midchg_period", 64'(p), 64'd1344);
        chk("midchg_pol", 64'(pol1), 64'd0);

        // Enable low holds at origin with inactive syncs; rising enable loads the new mode.
        enable = 1'b0;
        tick(); tick(); tick();
        chk("en0_hcnt", 64'(hc1), 64'd0);
        chk("en0_de", 64'(de1), 64'd0);
        chk("en0_hs_inactive", 64'(hs1), 64'd1);
        enable = 1'b1;
        tick();
        chk("enrise_fs", 64'(fs1), 64'd1);
        chk("enrise_pol", 64'(pol1), 64'd1);
        measure_lines("newmode", 2 * 1650 + 20, 1'b1, p, d, hl, ho);
        chk("newmode_period", 64'(p), 64'd1650);
        chk("newmode_de", 64'(d), 64'd1280);

        // Underflow: ten empty cycles inside active video, cleared by the next frame_start.
        do_reset(2'd2);
        rst = 1'b0; enable = 1'b1;
        for (int n = 0; n < 400 && hc1 != 12'd200; n++) tick();
        chk("uf_reach_hcnt", 64'(hc1), 64'd200);
        empty = 1'b1;
        for (int n = 0; n < 10; n++) tick();
        empty = 1'b0;
        tick();
`ifdef VTG_UNDERFLOW_EN
        chk("uf_flag", 64'(uf1), 64'd1);
        chk("uf_count", 64'(ufc1), 64'd10);
`else
        chk("uf_flag_off", 64'(uf1), 64'd0);
        chk("uf_count_off", 64'(ufc1), 64'd0);
`endif
        enable = 1'b0;
        tick();
        enable = 1'b1;
        tick();
        tick();
        chk("uf_flag_cleared", 64'(uf1), 64'd0);
        chk("uf_count_cleared", 64'(ufc1), 64'd0);

        // Randomized segments against the model.
        for (int s = 0; s < 25; s++) begin
            int len;
            mode   = 2'($urandom_range(0, 3));
            enable = ($urandom_range(0, 9) != 0);
            rst    = ($urandom_range(0, 7) == 0);
            len    = $urandom_range(50, 600);
            for (int n = 0; n < len; n++) begin
                empty = ($urandom_range(0, 3) == 0);
                if ($urandom_range(0, 199) == 0) enable = ~enable;
                if ($urandom_range(0, 299) == 0) mode = 2'($urandom_range(0, 3));
                tick();
                rst = 1'b0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
